// File: rtl/iob_cpu_bus_arb.sv
// Two-requester (instruction/data) arbiter in front of a single IOb-style memory port.
// Define IOB_CPU_BUS_ARB_RR_EN for round-robin arbitration; otherwise data wins over instruction.
module iob_cpu_bus_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,

  input  logic                i_avalid_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_wdata_i,
  input  logic [DATA_W/8-1:0] i_wstrb_i,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_rvalid_o,
  output logic                i_ready_o,

  input  logic                d_avalid_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_rvalid_o,
  output logic                d_ready_o,

  output logic                m_avalid_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_rvalid_i,
  input  logic                m_ready_i,

  output logic                busy_o,
  output logic [1:0]          state_o,
  output logic                gnt_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              arb_gnt;
  logic              req_any;
  logic              in_req, in_wait;
  logic              g_avalid, g_write, g_ready, g_rvalid;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;

`ifdef IOB_CPU_BUS_ARB_RR_EN
  logic              last_gnt_q, last_gnt_d;
`endif

  // Arbitration decision, only consumed while IDLE.
  always_comb begin
    req_any = i_avalid_i | d_avalid_i;
`ifdef IOB_CPU_BUS_ARB_RR_EN
    arb_gnt = (i_avalid_i & d_avalid_i) ? ~last_gnt_q : d_avalid_i;
`else
    arb_gnt = d_avalid_i;
`endif
  end

  // Handshake: a request is accepted in the cycle m_avalid_o and m_ready_i are both high;
  // read data is taken in the cycle m_rvalid_i is high. Writes (wstrb != 0) get no rvalid.
  always_comb begin
    in_req   = (state_q == REQ);
    in_wait  = (state_q == WAIT_R);
    g_avalid = gnt_q ? d_avalid_i : i_avalid_i;
    g_addr   = gnt_q ? d_addr_i   : i_addr_i;
    g_wdata  = gnt_q ? d_wdata_i  : i_wdata_i;
    g_wstrb  = gnt_q ? d_wstrb_i  : i_wstrb_i;
    g_write  = |g_wstrb;
    g_ready  = in_req & m_ready_i;
    g_rvalid = (in_req & g_avalid & m_ready_i & ~g_write & m_rvalid_i) |
               (in_wait & m_rvalid_i);
  end

  assign m_avalid_o = in_req & g_avalid;
  assign m_addr_o   = in_req ? g_addr  : '0;
  assign m_wdata_o  = in_req ? g_wdata : '0;
  assign m_wstrb_o  = in_req ? g_wstrb : '0;

  assign i_ready_o  = g_ready & ~gnt_q;
  assign d_ready_o  = g_ready &  gnt_q;
  assign i_rvalid_o = g_rvalid & ~gnt_q;
  assign d_rvalid_o = g_rvalid &  gnt_q;

  // Read data fans out unconditionally; only rvalid selects the consumer.
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;

  assign busy_o     = (state_q != IDLE);
  assign state_o    = state_q;
  assign gnt_o      = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
`ifdef IOB_CPU_BUS_ARB_RR_EN
    last_gnt_d = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = REQ;
          gnt_d   = arb_gnt;
`ifdef IOB_CPU_BUS_ARB_RR_EN
          last_gnt_d = arb_gnt;
`endif
        end
      end
      REQ: begin
        // A requester withdrawing before acceptance simply cancels the slot.
        if (!g_avalid) begin
          state_d = IDLE;
        end else if (m_ready_i) begin
          if (g_write || m_rvalid_i) state_d = IDLE;
          else                       state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
`ifdef IOB_CPU_BUS_ARB_RR_EN
      last_gnt_q <= 1'b0;
`endif
    end else if (cke_i) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
`ifdef IOB_CPU_BUS_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_cpu_bus_arb.sv
// Self-checking bench for iob_cpu_bus_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration order and response routing.
module tb_iob_cpu_bus_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i, cke_i;
  logic          i_avalid_i, d_avalid_i, m_rvalid_i, m_ready_i;
  logic [AW-1:0] i_addr_i, d_addr_i;
  logic [DW-1:0] i_wdata_i, d_wdata_i, m_rdata_i;
  logic [SW-1:0] i_wstrb_i, d_wstrb_i;
  logic [DW-1:0] i_rdata_o, d_rdata_o;
  logic          i_rvalid_o, i_ready_o, d_rvalid_o, d_ready_o;
  logic          m_avalid_o, busy_o, gnt_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic [SW-1:0] m_wstrb_o;
  logic [1:0]    state_o;

  int pass_cnt = 0;
  int total    = 0;
  logic model_last;

  iob_cpu_bus_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cke_i(cke_i),
    .i_avalid_i(i_avalid_i), .i_addr_i(i_addr_i), .i_wdata_i(i_wdata_i), .i_wstrb_i(i_wstrb_i),
    .i_rdata_o(i_rdata_o), .i_rvalid_o(i_rvalid_o), .i_ready_o(i_ready_o),
    .d_avalid_i(d_avalid_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
    .d_rdata_o(d_rdata_o), .d_rvalid_o(d_rvalid_o), .d_ready_o(d_ready_o),
    .m_avalid_o(m_avalid_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_rdata_i(m_rdata_i), .m_rvalid_i(m_rvalid_i), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .state_o(state_o), .gnt_o(gnt_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic clear_inputs();
    i_avalid_i = 0; i_addr_i = '0; i_wdata_i = '0; i_wstrb_i = '0;
    d_avalid_i = 0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
    m_rdata_i = '0; m_rvalid_i = 0; m_ready_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i); rst_n_i = 0; clear_inputs(); cke_i = 1;
    @(negedge clk_i); rst_n_i = 1; #1;
  endtask

  // Reference rule: who wins when both requesters ask at once.
  function automatic logic pick_both();
`ifdef IOB_CPU_BUS_ARB_RR_EN
    return ~model_last;
`else
    return 1'b1;
`endif
  endfunction

  task automatic test_reset();
    clear_inputs(); cke_i = 0; rst_n_i = 0;
    @(negedge clk_i); @(negedge clk_i); #1;
    total++;
    if ({m_avalid_o, i_ready_o, d_ready_o, i_rvalid_o, d_rvalid_o, busy_o, gnt_o, state_o} !== 9'd0) $display("FAIL reset_ctrl: got %b expected 0", {m_avalid_o, i_ready_o, d_ready_o, i_rvalid_o, d_rvalid_o, busy_o, gnt_o, state_o});
    else pass_cnt++;
    total++;
    if ({m_addr_o, m_wdata_o, m_wstrb_o} !== '0) $display("FAIL reset_bus: got %h expected 0", {m_addr_o, m_wdata_o, m_wstrb_o});
    else pass_cnt++;
    d_avalid_i = 1; d_addr_i = 32'h55; m_ready_i = 1; m_rvalid_i = 1; m_rdata_i = 32'hA5A5_0001;
    @(negedge clk_i); #1;
    total++;
    if ({m_avalid_o, d_ready_o, d_rvalid_o, busy_o} !== 4'd0) $display("FAIL reset_held: got %b expected 0", {m_avalid_o, d_ready_o, d_rvalid_o, busy_o});
    else pass_cnt++;
    total++;
    if (d_rdata_o !== 32'hA5A5_0001 || i_rdata_o !== 32'hA5A5_0001) $display("FAIL reset_rdata: got %h/%h expected a5a50001", i_rdata_o, d_rdata_o);
    else pass_cnt++;
    @(negedge clk_i); clear_inputs(); cke_i = 1; rst_n_i = 1; #1;
  endtask

  task automatic test_d_read();
    int rdy_n = 0, rv_n = 0, busy_n = 0, i_bad = 0;
    logic rd_ok = 0, addr_ok = 0;
    d_addr_i = 32'h100; d_wstrb_i = '0; d_wdata_i = $urandom; d_avalid_i = 1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_i);
      m_ready_i  = (c == 2);
      m_rvalid_i = (c == 4);
      m_rdata_i  = (c == 4) ? 32'hDEADBEEF : $urandom;
      if (c == 3) d_avalid_i = 0;
      #1;
      if (d_ready_o) rdy_n++;
      if (d_rvalid_o) begin
        rv_n++;
        if (d_rdata_o === 32'hDEADBEEF) rd_ok = 1;
      end
      if (busy_o) busy_n++;
      if (i_ready_o || i_rvalid_o) i_bad++;
      if (c == 1 && m_avalid_o && m_addr_o === 32'h100) addr_ok = 1;
    end
    total++; if (addr_ok !== 1'b1) $display("FAIL dread_addr: got %b expected 1", addr_ok); else pass_cnt++;
    total++; if (rdy_n != 1) $display("FAIL dread_ready_pulses: got %0d expected 1", rdy_n); else pass_cnt++;
    total++; if (rv_n != 1) $display("FAIL dread_rvalid_pulses: got %0d expected 1", rv_n); else pass_cnt++;
    total++; if (rd_ok !== 1'b1) $display("FAIL dread_rdata: got %b expected 1", rd_ok); else pass_cnt++;
    total++; if (i_bad != 0) $display("FAIL dread_i_quiet: got %0d expected 0", i_bad); else pass_cnt++;
    total++; if (busy_n < 3) $display("FAIL dread_busy: got %0d expected >=3", busy_n); else pass_cnt++;
    total++; if (busy_o !== 1'b0) $display("FAIL dread_end_idle: got %b expected 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_d_write();
    d_addr_i = 32'h200; d_wdata_i = 32'h12345678; d_wstrb_i = 4'hF; d_avalid_i = 1;
    @(negedge clk_i); #1;
    total++;
    if ({m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o} !== {1'b1, 32'h200, 32'h12345678, 4'hF}) $display("FAIL dwrite_fields: got %h expected %h", {m_avalid_o, m_addr_o, m_wdata_o, m_wstrb_o}, {1'b1, 32'h200, 32'h12345678, 4'hF});
    else pass_cnt++;
    total++; if (d_ready_o !== 1'b0) $display("FAIL dwrite_ready_early: got %b expected 0", d_ready_o); else pass_cnt++;
    m_ready_i = 1; #1;
    total++; if ({d_ready_o, d_rvalid_o, i_ready_o} !== 3'b100) $display("FAIL dwrite_accept: got %b expected 100", {d_ready_o, d_rvalid_o, i_ready_o}); else pass_cnt++;
    @(negedge clk_i); m_ready_i = 0; d_avalid_i = 0; m_rvalid_i = 1; #1;
    total++; if ({busy_o, d_rvalid_o, m_avalid_o} !== 3'b000) $display("FAIL dwrite_idle: got %b expected 000", {busy_o, d_rvalid_o, m_avalid_o}); else pass_cnt++;
    total++; if ({m_addr_o, m_wdata_o, m_wstrb_o} !== '0) $display("FAIL dwrite_bus_zero: got %h expected 0", {m_addr_o, m_wdata_o, m_wstrb_o}); else pass_cnt++;
    @(negedge clk_i); clear_inputs(); #1;
  endtask

  task automatic test_same_cycle();
    logic saw_wait = 0;
    i_addr_i = 32'h40; i_wstrb_i = '0; i_avalid_i = 1;
    @(negedge clk_i); #1;
    if (state_o == 2'd2) saw_wait = 1;
    m_ready_i = 1; m_rvalid_i = 1; m_rdata_i = 32'hCAFEF00D; #1;
    total++;
    if ({i_ready_o, i_rvalid_o, d_ready_o, d_rvalid_o} !== 4'b1100 || i_rdata_o !== 32'hCAFEF00D) $display("FAIL same_cycle_resp: got %b/%h expected 1100/cafef00d", {i_ready_o, i_rvalid_o, d_ready_o, d_rvalid_o}, i_rdata_o);
    else pass_cnt++;
    @(negedge clk_i); clear_inputs(); #1;
    if (state_o == 2'd2) saw_wait = 1;
    total++; if (busy_o !== 1'b0) $display("FAIL same_cycle_idle: got %b expected 0", busy_o); else pass_cnt++;
    @(negedge clk_i); #1;
    if (state_o == 2'd2) saw_wait = 1;
    total++; if (saw_wait !== 1'b0) $display("FAIL same_cycle_no_wait: got %b expected 0", saw_wait); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic          exp_g;
    logic [AW-1:0] exp_a;
    do_reset();
    i_addr_i = 32'h1000; d_addr_i = 32'h2000; i_avalid_i = 1; d_avalid_i = 1;
    @(negedge clk_i); #1;
    total++; if ({gnt_o, m_addr_o} !== {1'b1, 32'h2000}) $display("FAIL simul_first: got %h expected %h", {gnt_o, m_addr_o}, {1'b1, 32'h2000}); else pass_cnt++;
    m_ready_i = 1; m_rvalid_i = 1; m_rdata_i = 32'h1111; #1;
    total++; if ({i_rvalid_o, d_rvalid_o} !== 2'b01) $display("FAIL simul_first_rv: got %b expected 01", {i_rvalid_o, d_rvalid_o}); else pass_cnt++;
    @(negedge clk_i); m_ready_i = 0; m_rvalid_i = 0;
`ifdef IOB_CPU_BUS_ARB_RR_EN
    d_avalid_i = 0; exp_g = 1'b0; exp_a = 32'h1000;
`else
    exp_g = 1'b1; exp_a = 32'h2000;
`endif
    #1;
    @(negedge clk_i); #1;
    total++; if ({gnt_o, m_addr_o} !== {exp_g, exp_a}) $display("FAIL simul_second: got %h expected %h", {gnt_o, m_addr_o}, {exp_g, exp_a}); else pass_cnt++;
    m_ready_i = 1; m_rvalid_i = 1; #1;
    total++; if ({i_rvalid_o, d_rvalid_o} !== {~exp_g, exp_g}) $display("FAIL simul_second_rv: got %b expected %b", {i_rvalid_o, d_rvalid_o}, {~exp_g, exp_g}); else pass_cnt++;
    @(negedge clk_i); clear_inputs(); #1;
  endtask

  task automatic test_reset_in_wait();
    d_addr_i = 32'h300; d_avalid_i = 1;
    @(negedge clk_i); #1;
    m_ready_i = 1; #1;
    @(negedge clk_i); m_ready_i = 0; d_avalid_i = 0; #1;
    total++; if (state_o !== 2'd2) $display("FAIL rstw_in_wait: got %0d expected 2", state_o); else pass_cnt++;
    @(negedge clk_i); rst_n_i = 0; #1;
    @(negedge clk_i); rst_n_i = 1; m_rvalid_i = 1; m_rdata_i = 32'h77; #1;
    total++; if ({busy_o, i_rvalid_o, d_rvalid_o} !== 3'b000) $display("FAIL rstw_late_rvalid: got %b expected 000", {busy_o, i_rvalid_o, d_rvalid_o}); else pass_cnt++;
    @(negedge clk_i); #1;
    total++; if ({busy_o, i_rvalid_o, d_rvalid_o} !== 3'b000) $display("FAIL rstw_still_idle: got %b expected 000", {busy_o, i_rvalid_o, d_rvalid_o}); else pass_cnt++;
    @(negedge clk_i); clear_inputs(); #1;
  endtask

  task automatic test_cke_hold();
    d_addr_i = 32'h400; d_avalid_i = 1;
    @(negedge clk_i); #1;
    m_ready_i = 1; #1;
    @(negedge clk_i); m_ready_i = 0; d_avalid_i = 0; #1;
    cke_i = 0; m_rvalid_i = 1; m_rdata_i = 32'hBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #1;
      total++;
      if ({state_o, gnt_o} !== {2'd2, 1'b1}) $display("FAIL cke_hold_%0d: got %b expected 101", c, {state_o, gnt_o});
      else pass_cnt++;
    end
    cke_i = 1; #1;
    total++; if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'hBEEF}) $display("FAIL cke_resume_rv: got %h expected %h", {d_rvalid_o, d_rdata_o}, {1'b1, 32'hBEEF}); else pass_cnt++;
    @(negedge clk_i); m_rvalid_i = 0; #1;
    total++; if (busy_o !== 1'b0) $display("FAIL cke_resume_idle: got %b expected 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_drop();
    d_addr_i = 32'h500; d_avalid_i = 1;
    @(negedge clk_i); #1;
    total++; if (m_avalid_o !== 1'b1) $display("FAIL drop_req: got %b expected 1", m_avalid_o); else pass_cnt++;
    @(negedge clk_i); d_avalid_i = 0; #1;
    total++; if ({m_avalid_o, d_ready_o} !== 2'b00) $display("FAIL drop_no_req: got %b expected 00", {m_avalid_o, d_ready_o}); else pass_cnt++;
    @(negedge clk_i); #1;
    total++; if (state_o !== 2'd0) $display("FAIL drop_idle: got %0d expected 0", state_o); else pass_cnt++;
    clear_inputs();
  endtask

  task automatic test_random(input int n);
    logic [AW-1:0] f_addr  [2];
    logic [DW-1:0] f_wdata [2];
    logic [SW-1:0] f_wstrb [2];
    logic          want    [2];
    logic          g, g0, is_rd;
    logic [1:0]    exp_rv;
    logic [DW-1:0] rdat;
    int            ng, waited, rd, rv;
    do_reset();
    model_last = 1'b0;
    for (int t = 0; t < n; t++) begin
      want[0] = 1'($urandom_range(0, 1));
      want[1] = 1'($urandom_range(0, 1));
      if (!want[0] && !want[1]) want[$urandom_range(0, 1)] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        f_addr[r]  = $urandom;
        f_wdata[r] = $urandom;
        f_wstrb[r] = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
      end
      i_addr_i = f_addr[0]; i_wdata_i = f_wdata[0]; i_wstrb_i = f_wstrb[0]; i_avalid_i = want[0];
      d_addr_i = f_addr[1]; d_wdata_i = f_wdata[1]; d_wstrb_i = f_wstrb[1]; d_avalid_i = want[1];
      g0 = (want[0] && want[1]) ? pick_both() : want[1];
      ng = (want[0] && want[1]) ? 2 : 1;
      for (int k = 0; k < ng; k++) begin
        g = (k == 0) ? g0 : ~g0;
        waited = 0;
        do begin
          @(negedge clk_i); #1; waited++;
        end while (!m_avalid_o && waited < 4);
        total++; if (waited != 1) $display("FAIL rnd_latency t%0d: got %0d expected 1", t, waited); else pass_cnt++;
        total++;
        if ({gnt_o, m_addr_o, m_wdata_o, m_wstrb_o} !== {g, f_addr[g], f_wdata[g], f_wstrb[g]}) $display("FAIL rnd_grant t%0d: got %h expected %h", t, {gnt_o, m_addr_o, m_wdata_o, m_wstrb_o}, {g, f_addr[g], f_wdata[g], f_wstrb[g]});
        else pass_cnt++;
        model_last = g;
        rd = $urandom_range(0, 2);
        for (int j = 0; j < rd; j++) begin
          total++; if ({i_ready_o, d_ready_o} !== 2'b00) $display("FAIL rnd_ready_early t%0d: got %b expected 00", t, {i_ready_o, d_ready_o}); else pass_cnt++;
          @(negedge clk_i); #1;
        end
        is_rd = (f_wstrb[g] == '0);
        rv = is_rd ? $urandom_range(0, 3) : 0;
        rdat = $urandom;
        m_ready_i = 1; m_rvalid_i = is_rd && (rv == 0); m_rdata_i = rdat; #1;
        exp_rv = (is_rd && rv == 0) ? {~g, g} : 2'b00;
        total++; if ({i_ready_o, d_ready_o} !== {~g, g}) $display("FAIL rnd_ready t%0d: got %b expected %b", t, {i_ready_o, d_ready_o}, {~g, g}); else pass_cnt++;
        total++; if ({i_rvalid_o, d_rvalid_o} !== exp_rv) $display("FAIL rnd_rvalid_hs t%0d: got %b expected %b", t, {i_rvalid_o, d_rvalid_o}, exp_rv); else pass_cnt++;
        @(negedge clk_i); m_ready_i = 0; m_rvalid_i = 0;
        if (g) d_avalid_i = 0; else i_avalid_i = 0;
        #1;
        if (is_rd && rv > 0) begin
          for (int j = 1; j < rv; j++) begin
            total++; if ({i_rvalid_o, d_rvalid_o, state_o} !== 4'b0010) $display("FAIL rnd_wait t%0d: got %b expected 0010", t, {i_rvalid_o, d_rvalid_o, state_o}); else pass_cnt++;
            @(negedge clk_i); #1;
          end
          rdat = $urandom; m_rvalid_i = 1; m_rdata_i = rdat; #1;
          total++;
          if ({i_rvalid_o, d_rvalid_o} !== {~g, g} || (g ? d_rdata_o : i_rdata_o) !== rdat) $display("FAIL rnd_rdata t%0d: got %b/%h expected %b/%h", t, {i_rvalid_o, d_rvalid_o}, (g ? d_rdata_o : i_rdata_o), {~g, g}, rdat);
          else pass_cnt++;
          @(negedge clk_i); m_rvalid_i = 0; #1;
        end
        total++; if ({busy_o, m_avalid_o} !== 2'b00) $display("FAIL rnd_idle t%0d: got %b expected 00", t, {busy_o, m_avalid_o}); else pass_cnt++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    cke_i = 1; rst_n_i = 0;
    test_reset();
    test_d_read();
    test_d_write();
    test_same_cycle();
    test_simultaneous();
    test_reset_in_wait();
    test_cke_hold();
    test_drop();
    test_random(60);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/iob_cpu_bus_arb.md
IOB_CPU_BUS_ARB -- requirements
Module: iob_cpu_bus_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of every port.
REQ-002 SHALL have parameter DATA_W, default 32: data width; wstrb width is DATA_W/8.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cke_i  input  1  clock enable; when low, all state holds.
REQ-006 SHALL have ports i_avalid_i/i_addr_i/i_wdata_i/i_wstrb_i  input  1/ADDR_W/DATA_W/DATA_W/8  instruction requester request.
REQ-007 SHALL have ports i_rdata_o/i_rvalid_o/i_ready_o  output  DATA_W/1/1  instruction requester response.
REQ-008 SHALL have ports d_avalid_i/d_addr_i/d_wdata_i/d_wstrb_i  input  1/ADDR_W/DATA_W/DATA_W/8  data requester request.
REQ-009 SHALL have ports d_rdata_o/d_rvalid_o/d_ready_o  output  DATA_W/1/1  data requester response.
REQ-010 SHALL have ports m_avalid_o/m_addr_o/m_wdata_o/m_wstrb_o  output  1/ADDR_W/DATA_W/DATA_W/8  shared memory request.
REQ-011 SHALL have ports m_rdata_i/m_rvalid_i/m_ready_i  input  DATA_W/1/1  shared memory response.
REQ-012 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT_R, and a 1-bit registered grant register gnt (0=instr, 1=data).
REQ-014 In IDLE, with any avalid high, SHALL load gnt per arbitration rule (REQ-026/027) and go to REQ next cycle; arbitration latency is exactly 1 cycle.
REQ-015 In IDLE, m_avalid_o SHALL be 0, and i_ready_o/d_ready_o/i_rvalid_o/d_rvalid_o SHALL be 0; m_rvalid_i is ignored.
REQ-016 In REQ, m_avalid_o/m_addr_o/m_wdata_o/m_wstrb_o SHALL combinationally equal the granted requester's request fields; the other requester sees ready=0.
REQ-017 In REQ, granted ready output SHALL equal m_ready_i combinationally.
REQ-018 In REQ, with m_ready_i=1 and wstrb≠0 (write), SHALL return to IDLE; no rvalid is generated for writes.
REQ-019 In REQ, with m_ready_i=1 and wstrb=0 (read), SHALL go to WAIT_R, unless m_rvalid_i=1 in the same cycle, in which case it SHALL forward rvalid and go to IDLE.
REQ-020 In WAIT_R, granted rvalid output SHALL equal m_rvalid_i; on m_rvalid_i=1, SHALL go to IDLE; m_avalid_o SHALL be 0.
REQ-021 i_rdata_o and d_rdata_o SHALL both be driven from m_rdata_i at all times; only rvalid is steered.
REQ-022 If the granted requester drops avalid in REQ before ready (protocol violation), SHALL return to IDLE without forwarding a request.
REQ-023 At most one transaction SHALL be outstanding; a new grant only follows IDLE, so back-to-back transactions are spaced at least 1 idle cycle.
REQ-024 Requesters SHALL hold request fields stable from avalid until ready; the block does not register request fields.
REQ-025 When not in REQ, m_addr_o/m_wdata_o/m_wstrb_o SHALL be 0.

Configuration
REQ-026 With macro IOB_CPU_BUS_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; a register last_gnt (reset 0 = instr last) updates on every grant.
REQ-027 Without IOB_CPU_BUS_ARB_RR_EN, arbitration SHALL be fixed priority: data over instruction on simultaneous requests; no last_gnt register exists.

Reset
REQ-028 On rising clk_i with rst_n_i=0 (regardless of cke_i), SHALL enter IDLE, gnt=0, last_gnt=0; all outputs except rdata SHALL be 0 next cycle.
REQ-029 Reset during REQ or WAIT_R SHALL abandon the transaction; a late m_rvalid_i after reset SHALL be ignored.

Verification
REQ-030 d read only, addr 0x100, mem ready 1 cycle after REQ, rvalid 2 cycles later with 0xDEADBEEF -> d_ready_o one pulse, d_rvalid_o one pulse with d_rdata_o=0xDEADBEEF, i_* outputs stay 0, busy_o high 3+ cycles.
REQ-031 i and d assert simultaneously (reads) with RR_EN, reset state -> data granted first, instruction second; without RR_EN and d re-requesting immediately -> data granted both times.
REQ-032 d write wstrb=0xF, addr 0x200, wdata 0x12345678 -> m_* equals d fields in REQ, d_ready_o on m_ready_i, FSM to IDLE, no d_rvalid_o.
REQ-033 read with m_ready_i and m_rvalid_i in same cycle -> ready and rvalid forwarded same cycle, IDLE next cycle, WAIT_R never entered.
REQ-034 rst_n_i low during WAIT_R, then m_rvalid_i=1 after reset release -> busy_o=0, no rvalid on either requester.
REQ-035 cke_i=0 for 3 cycles in WAIT_R -> state and gnt unchanged; completes normally when cke_i returns high.
